// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RISC-V control FSM with memory wait timeout and retire counter
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit BRANCH_EN = 1'b1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           Opcode,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 IorD,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 PCSrc,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 Fault,
  output logic [3:0]           State,
  output logic [CNT_WIDTH-1:0] Retired
);
  localparam int WW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
                         MEM_ADDR = 4'd4, MEM_READ = 4'd5, MEM_WRITE = 4'd6, WB_ALU = 4'd7,
                         WB_MEM = 4'd8, BRANCH = 4'd9, FAULT = 4'd10;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;
  logic [3:0]    state, nxt;
  logic [WW-1:0] wcnt;
  logic          wait_st, expired;
  assign wait_st = state == FETCH || state == MEM_READ || state == MEM_WRITE;
  assign expired = MEM_TIMEOUT != 0 && !MemReady && wcnt == WW'(MEM_TIMEOUT);
  assign State = state;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      wcnt    <= '0;
      Retired <= '0;
    end else begin
      state <= nxt;
      // the counter only survives while we stay parked in a wait state
      wcnt  <= (wait_st && nxt == state) ? wcnt + 1'b1 : '0;
      if (nxt == FETCH && state != FETCH) Retired <= Retired + 1'b1;
    end
  end
  always_comb begin
    nxt = FAULT;
    case (state)
      FETCH:          nxt = MemReady ? DECODE : expired ? FAULT : FETCH;
      DECODE:         nxt = Opcode == OP_R ? EXEC_R :
                            Opcode == OP_I ? EXEC_I :
                            (Opcode == OP_LW || Opcode == OP_SW) ? MEM_ADDR :
                            (BRANCH_EN && Opcode == OP_BEQ) ? BRANCH : FAULT;
      EXEC_R, EXEC_I: nxt = WB_ALU;
      MEM_ADDR:       nxt = Opcode == OP_LW ? MEM_READ : MEM_WRITE;
      MEM_READ:       nxt = MemReady ? WB_MEM : expired ? FAULT : MEM_READ;
      MEM_WRITE:      nxt = MemReady ? FETCH : expired ? FAULT : MEM_WRITE;
      WB_ALU, WB_MEM, BRANCH: nxt = FETCH;
      default:        nxt = FAULT;
    endcase
  end
  always_comb begin
    {PCWrite, IRWrite, IorD, PCSrc, MemtoReg, RegWrite, MemRead, MemWrite, Fault} = '0;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ALUOp   = 2'b00;
    case (state)
      FETCH:     begin MemRead = 1'b1; ALUSrcB = 2'b01; IRWrite = MemReady; PCWrite = MemReady; end
      DECODE:    ALUSrcB = 2'b10;
      EXEC_R:    begin ALUSrcA = 2'b01; ALUOp = 2'b10; end
      EXEC_I:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUOp = 2'b10; end
      MEM_ADDR:  begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
      MEM_READ:  begin MemRead = 1'b1; IorD = 1'b1; end
      MEM_WRITE: begin MemWrite = 1'b1; IorD = 1'b1; end
      WB_ALU:    RegWrite = 1'b1;
      WB_MEM:    begin RegWrite = 1'b1; MemtoReg = 1'b1; end
      BRANCH:    begin ALUSrcA = 2'b01; ALUOp = 2'b01; PCSrc = 1'b1; PCWrite = Zero; end
      FAULT:     Fault = 1'b1;
      default:   ;
    endcase
    // strobes are held off while reset is asserted, even though state already reads FETCH
    if (!reset_n) {PCWrite, IRWrite, RegWrite, MemRead, MemWrite} = '0;
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized bench comparing the FSM against a per-instruction trace model
module tb_multicycle_controller;
  localparam int TO = 15;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011,
                         BEQ = 7'b1100011;
  logic clk = 1'b0, reset_n = 1'b0, Zero = 1'b0, MemReady = 1'b0;
  logic [6:0] Opcode = '0;
  logic PCWrite, IRWrite, IorD, PCSrc, MemtoReg, RegWrite, MemRead, MemWrite, Fault;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] State;
  logic [31:0] Retired;
  logic nb_PCWrite, nb_IRWrite, nb_IorD, nb_PCSrc, nb_MemtoReg, nb_RegWrite, nb_MemRead, nb_MemWrite, nb_Fault;
  logic [1:0] nb_ALUSrcA, nb_ALUSrcB, nb_ALUOp;
  logic [3:0] nb_State;
  logic [31:0] nb_Retired;
  logic w_PCWrite, w_IRWrite, w_IorD, w_PCSrc, w_MemtoReg, w_RegWrite, w_MemRead, w_MemWrite, w_Fault;
  logic [1:0] w_ALUSrcA, w_ALUSrcB, w_ALUOp;
  logic [3:0] w_State;
  logic [3:0] w_Retired;
  int n_chk = 0, n_pass = 0, ret_cnt = 0;
  int exp_st[$];
  logic exp_rdy[$];

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Fault(Fault), .State(State), .Retired(Retired));
  multicycle_controller #(.BRANCH_EN(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(nb_PCWrite), .IRWrite(nb_IRWrite), .IorD(nb_IorD), .ALUSrcA(nb_ALUSrcA),
    .ALUSrcB(nb_ALUSrcB), .ALUOp(nb_ALUOp), .PCSrc(nb_PCSrc), .MemtoReg(nb_MemtoReg),
    .RegWrite(nb_RegWrite), .MemRead(nb_MemRead), .MemWrite(nb_MemWrite), .Fault(nb_Fault),
    .State(nb_State), .Retired(nb_Retired));
  multicycle_controller #(.CNT_WIDTH(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(w_PCWrite), .IRWrite(w_IRWrite), .IorD(w_IorD), .ALUSrcA(w_ALUSrcA),
    .ALUSrcB(w_ALUSrcB), .ALUOp(w_ALUOp), .PCSrc(w_PCSrc), .MemtoReg(w_MemtoReg),
    .RegWrite(w_RegWrite), .MemRead(w_MemRead), .MemWrite(w_MemWrite), .Fault(w_Fault),
    .State(w_State), .Retired(w_Retired));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // {MemRead,MemWrite,RegWrite,PCWrite,IRWrite,MemtoReg,PCSrc,IorD,Fault,ALUSrcA,ALUSrcB,ALUOp}
  function automatic logic [14:0] exp_out(int st, logic r, logic z);
    logic mr = 0, mw = 0, rw = 0, pw = 0, iw = 0, m2r = 0, ps = 0, iod = 0, ft = 0;
    logic [1:0] a = 2'b00, b = 2'b00, op = 2'b00;
    case (st)
      0:  begin mr = 1; b = 2'b01; pw = r; iw = r; end
      1:  b = 2'b10;
      2:  begin a = 2'b01; op = 2'b10; end
      3:  begin a = 2'b01; b = 2'b10; op = 2'b10; end
      4:  begin a = 2'b01; b = 2'b10; end
      5:  begin mr = 1; iod = 1; end
      6:  begin mw = 1; iod = 1; end
      7:  rw = 1;
      8:  begin rw = 1; m2r = 1; end
      9:  begin a = 2'b01; op = 2'b01; ps = 1; pw = z; end
      10: ft = 1;
      default: ;
    endcase
    return {mr, mw, rw, pw, iw, m2r, ps, iod, ft, a, b, op};
  endfunction

  task automatic push(int st, logic r);
    exp_st.push_back(st);
    exp_rdy.push_back(r);
  endtask

  // a wait of w cycles either completes after w idle cycles or expires after TO+1
  task automatic phase(int st, int w, output bit f);
    int n = w > TO ? TO + 1 : w;
    for (int k = 0; k < n; k++) push(st, 1'b0);
    f = w > TO;
    if (!f) push(st, 1'b1);
  endtask

  task automatic build(logic [6:0] op, int fw, int mw, output bit f);
    exp_st.delete();
    exp_rdy.delete();
    phase(0, fw, f);
    if (!f) begin
      push(1, 1'($urandom));
      case (op)
        R:   begin push(2, 1'($urandom)); push(7, 1'($urandom)); end
        I:   begin push(3, 1'($urandom)); push(7, 1'($urandom)); end
        LW:  begin push(4, 1'($urandom)); phase(5, mw, f); if (!f) push(8, 1'($urandom)); end
        SW:  begin push(4, 1'($urandom)); phase(6, mw, f); end
        BEQ: push(9, 1'($urandom));
        default: f = 1;
      endcase
    end
    if (f) repeat (3) push(10, 1'($urandom));
  endtask

  task automatic run(logic [6:0] op, logic z, int fw, int mw, output bit f);
    logic [14:0] got, want;
    Opcode = op;
    Zero = z;
    build(op, fw, mw, f);
    n_chk++;
    if (Retired !== 32'(ret_cnt)) $display("FAIL retired: got %0d want %0d", Retired, ret_cnt);
    else n_pass++;
    n_chk++;
    if (w_Retired !== 4'(ret_cnt)) $display("FAIL retired_w4: got %0d want %0d", w_Retired, 4'(ret_cnt));
    else n_pass++;
    foreach (exp_st[i]) begin
      MemReady = exp_rdy[i];
      #1;
      n_chk++;
      if (State !== 4'(exp_st[i])) $display("FAIL state[%0d] op=%b: got %0d want %0d", i, op, State, exp_st[i]);
      else n_pass++;
      got = {MemRead, MemWrite, RegWrite, PCWrite, IRWrite, MemtoReg, PCSrc, IorD, Fault, ALUSrcA, ALUSrcB, ALUOp};
      want = exp_out(exp_st[i], exp_rdy[i], z);
      n_chk++;
      if (got !== want) $display("FAIL outputs[%0d] st=%0d: got %b want %b", i, exp_st[i], got, want);
      else n_pass++;
      if (exp_st[i] == 9) begin
        n_chk++;
        if (nb_State !== 4'd10) $display("FAIL nobranch_fault: got state %0d want 10", nb_State);
        else n_pass++;
      end
      @(posedge clk);
      #1;
    end
    if (!f) ret_cnt++;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ret_cnt = 0;
  endtask

  task automatic test_reset;
    Opcode = LW;
    MemReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    MemReady = 1'b0;
    #1;
    n_chk++;
    if (State !== 4'd5) $display("FAIL pre_reset_state: got %0d want 5", State); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({State, Fault} !== 5'd0) $display("FAIL reset_state: got %0d/%b want 0/0", State, Fault); else n_pass++;
    n_chk++;
    if (Retired !== 32'd0) $display("FAIL reset_retired: got %0d want 0", Retired); else n_pass++;
    n_chk++;
    if ({MemRead, MemWrite, RegWrite, PCWrite, IRWrite} !== 5'd0)
      $display("FAIL reset_strobes: got %b want 00000", {MemRead, MemWrite, RegWrite, PCWrite, IRWrite});
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if ({State, MemRead} !== 5'd0) $display("FAIL reset_hold: got %0d/%b want 0/0", State, MemRead); else n_pass++;
    reset_n = 1'b1;
    ret_cnt = 0;
    #1;
    n_chk++;
    if (MemRead !== 1'b1) $display("FAIL release_memread: got %b want 1", MemRead); else n_pass++;
  endtask

  task automatic test_alu;
    bit f;
    do_reset();
    run(R, 1'b0, 0, 0, f);
    run(I, 1'b1, 0, 0, f);
    n_chk++;
    if (Retired !== 32'd2) $display("FAIL alu_retired: got %0d want 2", Retired); else n_pass++;
  endtask

  task automatic test_mem;
    bit f;
    run(LW, 1'b0, 0, 3, f);
    run(SW, 1'b0, $urandom_range(0, 2), $urandom_range(0, 4), f);
  endtask

  task automatic test_branch;
    bit f;
    run(BEQ, 1'b1, 0, 0, f);
    run(BEQ, 1'b0, 0, 0, f);
  endtask

  task automatic test_timeout;
    bit f;
    run(R, 1'b0, 16, 0, f);
    n_chk++;
    if (!f) $display("FAIL timeout_model: got nofault want fault"); else n_pass++;
    do_reset();
    run(R, 1'b0, 15, 0, f);
    run(LW, 1'b0, 0, 16, f);
    do_reset();
    run(SW, 1'b0, 0, 15, f);
    run(SW, 1'b0, 0, 16, f);
    do_reset();
  endtask

  task automatic test_illegal;
    bit f;
    run(7'b1111111, 1'b0, 0, 0, f);
    do_reset();
  endtask

  task automatic test_wrap;
    bit f;
    do_reset();
    repeat (16) run($urandom_range(0, 1) ? R : I, 1'b0, 0, 0, f);
    n_chk++;
    if (w_Retired !== 4'd0) $display("FAIL wrap_w4: got %0d want 0", w_Retired); else n_pass++;
    n_chk++;
    if (Retired !== 32'd16) $display("FAIL wrap_main: got %0d want 16", Retired); else n_pass++;
  endtask

  task automatic test_random;
    bit f;
    logic [6:0] ops [6] = '{R, I, LW, SW, BEQ, 7'b1101111};
    for (int k = 0; k < 40; k++) begin
      int fw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      int mw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      run(ops[$urandom_range(0, 5)], 1'($urandom), fw, mw, f);
      if (f) do_reset();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_timeout();
    test_illegal();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle main control FSM for the RISC-V datapath. It is the sequential successor to the single-cycle opcode decoder and supports the same R-type, I-type ALU, lw and sw classes, plus optional beq. It sequences each instruction over several states. It also handles memory wait-states through a ready handshake, guards those waits with a timeout, and counts retired instructions. It sits between the instruction register and the shared-memory multi-cycle datapath.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles spent waiting on `MemReady` in one memory state; 0 disables the timeout.
- `BRANCH_EN`, default 1: 1 decodes opcode 1100011 (beq); 0 treats it as illegal.
- `CNT_WIDTH`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `Opcode` in 7: IR[6:0], stable from DECODE until FETCH.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC load enable.
- `IRWrite` out 1: IR load enable.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ALUSrcA` out 2: 00 = PC, 01 = rs1.
- `ALUSrcB` out 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct decode.
- `PCSrc` out 1: 0 = ALU result, 1 = ALUOut (branch target).
- `MemtoReg` out 1: write-back select; 1 = memory data.
- `RegWrite` out 1: register file write enable.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe.
- `Fault` out 1: sticky error flag.
- `State` out 4: current state encoding, for debug.
- `Retired` out CNT_WIDTH: count of completed instructions.

## Operation
States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_READ=5, MEM_WRITE=6, WB_ALU=7, WB_MEM=8, BRANCH=9, FAULT=10. Codes 11–15 are unreachable and go to FAULT if ever seen.

Outputs are Moore, decoded from state. Any output not listed for a state is 0.

- **FETCH**: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00. IRWrite=PCWrite=MemReady, combinational. Stays in FETCH until MemReady, then goes to DECODE.
- **DECODE**: ALUSrcA=00, ALUSrcB=10, ALUOp=00 (computes the branch target into ALUOut). Next state by Opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 with BRANCH_EN=1 → BRANCH
  - anything else → FAULT
- **EXEC_R**: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Goes to WB_ALU.
- **EXEC_I**: ALUSrcA=01, ALUSrcB=10, ALUOp=10. Goes to WB_ALU.
- **MEM_ADDR**: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Goes to MEM_READ if Opcode=0000011, otherwise MEM_WRITE.
- **MEM_READ**: MemRead=1, IorD=1. Waits for MemReady, then goes to WB_MEM.
- **MEM_WRITE**: MemWrite=1, IorD=1. Waits for MemReady, then goes to FETCH and the instruction retires.
- **WB_ALU**: RegWrite=1, MemtoReg=0. Goes to FETCH and retires.
- **WB_MEM**: RegWrite=1, MemtoReg=1. Goes to FETCH and retires.
- **BRANCH**: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero (combinational). Goes to FETCH and retires whether or not the branch is taken.
- **FAULT**: Fault=1 and all strobes 0. Absorbing; only reset_n exits it.

Wait timeout:
- The wait counter has width clog2(MEM_TIMEOUT+1). It is cleared on entry to FETCH, MEM_READ or MEM_WRITE.
- It increments on each cycle in those states with MemReady=0.
- When it equals MEM_TIMEOUT and MemReady=0, the next state is FAULT.
- If MemReady=1 in that same cycle, MemReady wins and the normal transition is taken.

Retired counter:
- Increments by 1 on each retiring transition into FETCH.
- Wraps modulo 2^CNT_WIDTH.
- Does not increment in FAULT.

## Timing
- reset_n low (asynchronous): State=FETCH, wait counter=0, Retired=0, Fault=0.
- While reset_n is low, MemRead, MemWrite, RegWrite, PCWrite and IRWrite are forced to 0.
- After reset_n rises, the FETCH strobes assert in the same cycle.
- State updates on the rising edge of clk.
- Latency with MemReady held at 1, FETCH through the retiring state:
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
- Each cycle MemReady is low in a memory state adds one cycle.
- Fault asserts on the first cycle in FAULT, i.e. the cycle after the illegal DECODE or the expired wait.

## Test plan
- **Reset**: assert reset_n low mid-way through MEM_READ → State=0, Retired=0, all strobes 0 during reset; MemRead=1 the cycle after release.
- **ALU sequence**: with MemReady=1, apply Opcode 0110011, then 0010011 → states 0,1,2,7 then 0,1,3,7; RegWrite=1 only in WB_ALU; Retired=2.
- **Memory with waits**: lw with MemReady low for 3 cycles in MEM_READ → states 0,1,4,5,5,5,5,8; MemtoReg=1 in WB_MEM. Then sw → MemWrite=1 in MEM_WRITE, RegWrite never 1.
- **Branch**: Opcode 1100011 with Zero=1 → PCWrite=1, PCSrc=1 in BRANCH. Repeat with Zero=0 → PCWrite=0. Both retire.
- **Timeout**: MEM_TIMEOUT=15 with MemReady held low in FETCH → FAULT after 16 cycles, Fault=1, strobes 0. Repeat with MemReady=1 on cycle 16 → DECODE, no fault.
- **Illegal opcode and wrap**: Opcode 1111111 → FAULT on cycle 3, sticky until reset. With BRANCH_EN=0, opcode 1100011 → FAULT. With CNT_WIDTH=4, 16 retirements → Retired=0.
